pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, width of PC and all address ports.
REQ-002 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 Parameter INC, default 4, sequential PC increment.
REQ-004 Parameter ALIGN_BITS, default 2, number of PC LSBs that shall be zero.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 stall  input  1  hold current PC (hazard/fetch back-pressure).
REQ-008 redirect_valid  input  1  branch/jump/flush redirect request.
REQ-009 redirect_target  input  XLEN  redirect address.
REQ-010 pc_out  output  XLEN  current fetch PC (registered).
REQ-011 pc_plus_inc  output  XLEN  pc_out + INC, combinational, modulo 2^XLEN.
REQ-012 pc_valid  output  1  pc_out is a valid fetch address this cycle.
REQ-013 misalign_err  output  1  one-cycle pulse: a redirect target was rejected.
REQ-014 redirect_pending  output  1  a redirect is buffered during stall.

Function
REQ-015 FSM states BOOT, RUN, HOLD; encoding is free.
REQ-016 BOOT: entered on reset; pc_valid=0; next edge -> RUN with pc_out unchanged (RESET_VECTOR).
REQ-017 RUN, stall=0, accepted redirect: pc_out <= redirect_target; stay RUN.
REQ-018 RUN, stall=0, no redirect: pc_out <= pc_out + INC, wrapping modulo 2^XLEN (all-ones region wraps to 0, no error).
REQ-019 RUN, stall=1, no redirect: pc_out held; stay RUN.
REQ-020 RUN, stall=1, accepted redirect: pc_out held; target captured in pending register; -> HOLD; redirect_pending=1 from next cycle.
REQ-021 HOLD, stall=1: pc_out held; a new accepted redirect overwrites the pending target (latest wins).
REQ-022 HOLD, stall=0, no new redirect: pc_out <= pending target; -> RUN; redirect_pending clears same edge.
REQ-023 HOLD, stall=0, new accepted redirect same cycle: pc_out <= new target (new wins over pending); -> RUN.
REQ-024 Redirect accepted only if redirect_target[ALIGN_BITS-1:0]==0; otherwise ignored entirely (no PC/pending change) and misalign_err=1 on the following cycle only.
REQ-025 Redirect and stall inputs in BOOT are ignored; no error raised.
REQ-026 pc_valid=1 in RUN and HOLD, 0 in BOOT.
REQ-027 Redirect latency: accepted unstalled redirect in cycle N appears on pc_out in cycle N+1.
REQ-028 pc_plus_inc always reflects current pc_out, including during stall and BOOT.

Reset
REQ-029 rst low asynchronously forces: state=BOOT, pc_out=RESET_VECTOR, pending register=0, redirect_pending=0, misalign_err=0, pc_valid=0.
REQ-030 Reset asserted mid-HOLD discards the pending redirect; no redirect applied after release.
REQ-031 First rising edge after rst deassertion executes BOOT->RUN; PC increments from the second edge.

Verification
REQ-032 Reset release, stall=0, no redirect, defaults -> pc_out 0,0,4,8,0xC on successive cycles; pc_valid 0,1,1,1,1.
REQ-033 In RUN at pc_out=0x10, redirect_valid=1 target=0x200, stall=0 -> next pc_out=0x200, then 0x204.
REQ-034 At pc_out=0x20, stall=1 for 3 cycles, redirect 0x100 in stall cycle 1 and 0x300 in stall cycle 2 -> pc_out stays 0x20, redirect_pending=1, on release pc_out=0x300 then 0x304.
REQ-035 Redirect target 0x102 in RUN at pc_out=0x40 -> pc_out advances to 0x44, misalign_err=1 for exactly one cycle.
REQ-036 XLEN=32 with pc_out forced via redirect to 0xFFFFFFFC, stall=0 -> next pc_out=0x00000000, pc_plus_inc=0x00000000 while pc_out=0xFFFFFFFC.
REQ-037 rst pulsed low between clock edges while in HOLD with pending 0x400 -> pc_out=RESET_VECTOR immediately, redirect_pending=0, sequence resumes per REQ-032.

Source files
------------

// File: rtl/pc_gen.sv
// Program counter generator: boot cycle, sequential increment, stall hold,
// redirect buffering during stall, and misaligned-target rejection.
module pc_gen #(
  parameter int                 XLEN         = 32,
  parameter logic [XLEN-1:0]    RESET_VECTOR = '0,
  parameter int                 INC          = 4,
  parameter int                 ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            pc_valid,
  output logic            misalign_err,
  output logic            redirect_pending
);

  // Mask form keeps ALIGN_BITS=0 legal (no zero-width slice).
  localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            err_q;

  logic aligned, active, accept, reject;

  // Redirects only count once out of BOOT; alignment decides accept vs reject.
  assign aligned = (redirect_target & ALIGN_MASK) == '0;
  assign active  = (state_q != BOOT);
  assign accept  = active && redirect_valid && aligned;
  assign reject  = active && redirect_valid && !aligned;

  // Next-state / next-PC selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!stall) begin
          pc_d = accept ? redirect_target : pc_q + INC_V;
        end else if (accept) begin
          pend_d  = redirect_target;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (stall) begin
          // Latest accepted redirect replaces the buffered one.
          if (accept) pend_d = redirect_target;
        end else begin
          // A fresh redirect in the release cycle beats the buffered one.
          pc_d    = accept ? redirect_target : pend_q;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State, PC, pending target and error pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      err_q   <= reject;
    end
  end

  assign pc_out           = pc_q;
  assign pc_plus_inc      = pc_q + INC_V;
  assign pc_valid         = active;
  assign misalign_err     = err_q;
  assign redirect_pending = (state_q == HOLD);

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: each step drives inputs, pushes the expected
// post-edge outputs, then pops and compares one cycle later.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] pc_out, pc_plus_inc;
  logic        pc_valid, misalign_err, redirect_pending;

  int tests  = 0;
  int failed = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inc;
    logic        vld;
    logic        pend;
    logic        err;
  } obs_t;

  typedef struct {
    bit          st;
    bit          rv;
    logic [31:0] tg;
    logic [31:0] pc;
    bit          vld;
    bit          pend;
    bit          err;
  } step_t;

  obs_t sb[$];

  pc_gen dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .pc_out           (pc_out),
    .pc_plus_inc      (pc_plus_inc),
    .pc_valid         (pc_valid),
    .misalign_err     (misalign_err),
    .redirect_pending (redirect_pending)
  );

  always #5 clk = ~clk;

  function automatic void push_exp(logic [31:0] pc, bit vld, bit pend, bit err);
    obs_t e;
    e.pc   = pc;
    e.inc  = pc + 32'd4;
    e.vld  = vld;
    e.pend = pend;
    e.err  = err;
    sb.push_back(e);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pc   = pc_out;
    o.inc  = pc_plus_inc;
    o.vld  = pc_valid;
    o.pend = redirect_pending;
    o.err  = misalign_err;
    return o;
  endfunction

  task automatic tick(step_t s);
    stall           = s.st;
    redirect_valid  = s.rv;
    redirect_target = s.tg;
    push_exp(s.pc, s.vld, s.pend, s.err);
    @(posedge clk);
    #1;
  endtask

  function automatic step_t mk(bit st, bit rv, logic [31:0] tg, logic [31:0] pc,
                               bit vld, bit pend, bit err);
    step_t s;
    s.st = st; s.rv = rv; s.tg = tg; s.pc = pc;
    s.vld = vld; s.pend = pend; s.err = err;
    return s;
  endfunction

  task automatic test_reset();
    obs_t got, exp;
    step_t s[$];
    // Held in reset across edges: PC parked at the reset vector, nothing valid.
    for (int i = 0; i < 3; i++) begin
      push_exp(32'h0, 0, 0, 0);
      @(posedge clk);
      #1;
      got = sample(); exp = sb.pop_front(); tests++;
      if (got !== exp) begin
        failed++;
        $display("FAIL reset_hold[%0d] got %h expected %h", i, got, exp);
      end
    end
    rst = 1'b1;
    push_exp(32'h0, 0, 0, 0);
    #1;
    got = sample(); exp = sb.pop_front(); tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL reset_release got %h expected %h", got, exp);
    end
    s.push_back(mk(0, 0, 0, 32'h0, 1, 0, 0));
    s.push_back(mk(0, 0, 0, 32'h4, 1, 0, 0));
    s.push_back(mk(0, 0, 0, 32'h8, 1, 0, 0));
    s.push_back(mk(0, 0, 0, 32'hC, 1, 0, 0));
    foreach (s[i]) begin
      tick(s[i]);
      got = sample(); exp = sb.pop_front(); tests++;
      if (got !== exp) begin
        failed++;
        $display("FAIL boot_seq[%0d] got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_redirect();
    obs_t got, exp;
    step_t s[$];
    s.push_back(mk(0, 0, 0,        32'h10,  1, 0, 0));
    s.push_back(mk(0, 1, 32'h200,  32'h200, 1, 0, 0));
    s.push_back(mk(0, 0, 0,        32'h204, 1, 0, 0));
    foreach (s[i]) begin
      tick(s[i]);
      got = sample(); exp = sb.pop_front(); tests++;
      if (got !== exp) begin
        failed++;
        $display("FAIL redirect[%0d] got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_stall();
    obs_t got, exp;
    step_t s[$];
    s.push_back(mk(1, 0, 0,       32'h204, 1, 0, 0));
    s.push_back(mk(1, 0, 0,       32'h204, 1, 0, 0));
    s.push_back(mk(0, 1, 32'h20,  32'h20,  1, 0, 0));
    s.push_back(mk(1, 1, 32'h100, 32'h20,  1, 1, 0));
    s.push_back(mk(1, 1, 32'h300, 32'h20,  1, 1, 0));
    s.push_back(mk(1, 0, 0,       32'h20,  1, 1, 0));
    s.push_back(mk(0, 0, 0,       32'h300, 1, 0, 0));
    s.push_back(mk(0, 0, 0,       32'h304, 1, 0, 0));
    foreach (s[i]) begin
      tick(s[i]);
      got = sample(); exp = sb.pop_front(); tests++;
      if (got !== exp) begin
        failed++;
        $display("FAIL stall[%0d] got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_new_wins();
    obs_t got, exp;
    step_t s[$];
    s.push_back(mk(1, 1, 32'h500, 32'h304, 1, 1, 0));
    s.push_back(mk(0, 1, 32'h600, 32'h600, 1, 0, 0));
    s.push_back(mk(0, 0, 0,       32'h604, 1, 0, 0));
    foreach (s[i]) begin
      tick(s[i]);
      got = sample(); exp = sb.pop_front(); tests++;
      if (got !== exp) begin
        failed++;
        $display("FAIL new_wins[%0d] got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_misalign();
    obs_t got, exp;
    step_t s[$];
    s.push_back(mk(0, 1, 32'h40,  32'h40,  1, 0, 0));
    s.push_back(mk(0, 1, 32'h102, 32'h44,  1, 0, 1));
    s.push_back(mk(0, 0, 0,       32'h48,  1, 0, 0));
    s.push_back(mk(1, 1, 32'h700, 32'h48,  1, 1, 0));
    s.push_back(mk(1, 1, 32'h702, 32'h48,  1, 1, 1));
    s.push_back(mk(0, 0, 0,       32'h700, 1, 0, 0));
    s.push_back(mk(0, 1, 32'h701, 32'h704, 1, 0, 1));
    s.push_back(mk(0, 0, 0,       32'h708, 1, 0, 0));
    s.push_back(mk(1, 1, 32'h30A, 32'h708, 1, 0, 1));
    s.push_back(mk(0, 0, 0,       32'h70C, 1, 0, 0));
    foreach (s[i]) begin
      tick(s[i]);
      got = sample(); exp = sb.pop_front(); tests++;
      if (got !== exp) begin
        failed++;
        $display("FAIL misalign[%0d] got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t got, exp;
    step_t s[$];
    s.push_back(mk(0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0));
    s.push_back(mk(0, 0, 0,             32'h0,         1, 0, 0));
    s.push_back(mk(0, 0, 0,             32'h4,         1, 0, 0));
    foreach (s[i]) begin
      tick(s[i]);
      got = sample(); exp = sb.pop_front(); tests++;
      if (got !== exp) begin
        failed++;
        $display("FAIL wrap[%0d] got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_boot_ignore();
    obs_t got, exp;
    step_t s[$];
    #2 rst = 1'b0;
    push_exp(32'h0, 0, 0, 0);
    #1;
    got = sample(); exp = sb.pop_front(); tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL boot_async got %h expected %h", got, exp);
    end
    #1 rst = 1'b1;
    // Stall plus misaligned redirect during BOOT: no effect, no error.
    s.push_back(mk(1, 1, 32'h103, 32'h0,   1, 0, 0));
    s.push_back(mk(1, 1, 32'h200, 32'h0,   1, 1, 0));
    s.push_back(mk(0, 0, 0,       32'h200, 1, 0, 0));
    foreach (s[i]) begin
      tick(s[i]);
      got = sample(); exp = sb.pop_front(); tests++;
      if (got !== exp) begin
        failed++;
        $display("FAIL boot_ignore[%0d] got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_hold();
    obs_t got, exp;
    step_t s[$];
    s.push_back(mk(1, 1, 32'h400, 32'h200, 1, 1, 0));
    tick(s[0]);
    got = sample(); exp = sb.pop_front(); tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL hold_setup got %h expected %h", got, exp);
    end
    s.delete();
    #1 rst = 1'b0;
    push_exp(32'h0, 0, 0, 0);
    #1;
    got = sample(); exp = sb.pop_front(); tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL hold_async_reset got %h expected %h", got, exp);
    end
    #1 rst = 1'b1;
    // Aligned redirect in BOOT is also ignored; pending 0x400 never shows.
    s.push_back(mk(0, 1, 32'h200, 32'h0, 1, 0, 0));
    s.push_back(mk(0, 0, 0,       32'h4, 1, 0, 0));
    s.push_back(mk(0, 0, 0,       32'h8, 1, 0, 0));
    s.push_back(mk(0, 0, 0,       32'hC, 1, 0, 0));
    foreach (s[i]) begin
      tick(s[i]);
      got = sample(); exp = sb.pop_front(); tests++;
      if (got !== exp) begin
        failed++;
        $display("FAIL post_reset[%0d] got %h expected %h", i, got, exp);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_redirect();
    test_stall();
    test_new_wins();
    test_misalign();
    test_wrap();
    test_boot_ignore();
    test_reset_hold();
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain left %0d expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
